// File: rtl/wb_pkg.sv
// Shared Wishbone types and constants for the wb_* slice.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } wb_slave_state_t;

    typedef enum logic [1:0] {
        RSP_ACK,
        RSP_ERR,
        RSP_RTY
    } wb_resp_t;

    // An access is refused when it is not word aligned or selects no byte lane.
    function automatic logic wb_bad_access(input logic [1:0] adr_lo, input logic [3:0] sel);
        return (adr_lo != 2'b00) || (sel == 4'h0);
    endfunction

endpackage

// File: rtl/wb_slave_if.sv
// Wishbone bus bundle (wb_bus_t) with master and slave views.
interface wb_bus_t;
    import wb_pkg::*;

    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [3:0]           sel;
    logic [31:0]          adr;
    logic [WB_DATA_W-1:0] dat_ms;
    logic [WB_DATA_W-1:0] dat_sm;
    logic                 ack;
    logic                 err;
    logic                 rty;
    logic                 tgd_sm;
    logic                 gnt;
    logic                 lock;

    modport master (
        output cyc, stb, we, sel, adr, dat_ms, lock,
        input  dat_sm, ack, err, rty, tgd_sm, gnt
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_ms, gnt, lock,
        output dat_sm, ack, err, rty, tgd_sm
    );

endinterface

// File: rtl/wb_slave_timeout.sv
// Load/count/expire counter bounding how long a local request may stay pending.
module wb_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (tick && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

    // Fires in the cycle whose increment would bring the count to TIMEOUT.
    always_comb begin
        expire = tick && (count == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/wb_slave.sv
// Wishbone slave endpoint: window decode, alignment check, one local request per access.
// Optional request timeout with RTY response is enabled by defining WB_SLAVE_TIMEOUT_EN.
module wb_slave
    import wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wb_bus_t.slave                wb_bus,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WB_DATA_W-1:0]  data_o,
    output logic [3:0]            we_o,
    output logic                  valid_o,
    input  logic [WB_DATA_W-1:0]  data_i,
    input  logic                  valid_i
);

    wb_slave_state_t state, state_d;
    wb_resp_t        resp, resp_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WB_DATA_W-1:0]  data_q;
    logic [3:0]            we_q;
    logic                  rd_q;
    logic [WB_DATA_W-1:0]  rdata_q;

    logic hit;
    logic take;
    logic bad;
    logic accept;
    logic expire;
    logic unused_bus;

    always_comb begin
        hit    = (wb_bus.adr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
        take   = (state == IDLE) && wb_bus.cyc && wb_bus.stb && hit;
        bad    = wb_bad_access(wb_bus.adr[1:0], wb_bus.sel);
        accept = take && !bad;
    end

    always_comb begin
        unused_bus = &{1'b0, wb_bus.gnt, wb_bus.lock};
    end

`ifdef WB_SLAVE_TIMEOUT_EN
    logic tmo_tick;

    always_comb begin
        tmo_tick = (state == REQ) && !valid_i;
    end

    wb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (accept),
        .tick   (tmo_tick),
        .expire (expire)
    );
`else
    logic unused_cfg;

    always_comb begin
        expire     = 1'b0;
        unused_cfg = (TIMEOUT == 0);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            resp  <= RSP_ACK;
        end else begin
            state <= state_d;
            resp  <= resp_d;
        end
    end

    // Priority in REQ: master abort, then local completion, then timeout.
    always_comb begin
        state_d = state;
        resp_d  = resp;
        case (state)
            IDLE: begin
                if (take) begin
                    if (bad) begin
                        resp_d  = RSP_ERR;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (!wb_bus.cyc) begin
                    state_d = IDLE;
                end else if (valid_i) begin
                    resp_d  = RSP_ACK;
                    state_d = RESP;
                end else if (expire) begin
                    resp_d  = RSP_RTY;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= '0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= wb_bus.adr[ADDR_WIDTH-1:0];
                data_q <= wb_bus.dat_ms;
                we_q   <= wb_bus.sel & {4{wb_bus.we}};
                rd_q   <= !wb_bus.we;
            end
            if ((state == REQ) && wb_bus.cyc && valid_i && rd_q) begin
                rdata_q <= data_i;
            end
        end
    end

    always_comb begin
        valid_o       = (state == REQ);
        addr_o        = addr_q;
        data_o        = data_q;
        we_o          = we_q;
        wb_bus.ack    = (state == RESP) && (resp == RSP_ACK);
        wb_bus.err    = (state == RESP) && (resp == RSP_ERR);
`ifdef WB_SLAVE_TIMEOUT_EN
        wb_bus.rty    = (state == RESP) && (resp == RSP_RTY);
`else
        wb_bus.rty    = 1'b0;
`endif
        wb_bus.dat_sm = ((state == RESP) && (resp == RSP_ACK) && rd_q) ? rdata_q : '0;
        wb_bus.tgd_sm = 1'b0;
    end

endmodule

// File: tb/tb_wb_slave.sv
// Directed self-checking bench for wb_slave; timeout cases run when WB_SLAVE_TIMEOUT_EN is defined.
module tb_wb_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr_o;
    logic [31:0] data_o;
    logic [3:0]  we_o;
    logic        valid_o;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned n_ack = 0, n_err = 0, n_rty = 0, n_req = 0;
    int unsigned a0, e0, r0, q0;
    logic        valid_prev = 1'b0;

    wb_bus_t bus ();

    wb_slave #(
        .BASE_ADDR (32'h1000_0000),
        .ADDR_WIDTH(12),
        .TIMEOUT   (4)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .wb_bus (bus),
        .addr_o (addr_o),
        .data_o (data_o),
        .we_o   (we_o),
        .valid_o(valid_o),
        .data_i (data_i),
        .valid_i(valid_i)
    );

    always #5 clk = ~clk;

    // Pulse and request-start counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.ack) n_ack++;
        if (bus.err) n_err++;
        if (bus.rty) n_rty++;
        if (valid_o && !valid_prev) n_req++;
        valid_prev = valid_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        a0 = n_ack;
        e0 = n_err;
        r0 = n_rty;
        q0 = n_req;
    endtask

    task automatic drive(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
        bus.cyc    = 1'b1;
        bus.stb    = 1'b1;
        bus.adr    = adr;
        bus.we     = we;
        bus.sel    = sel;
        bus.dat_ms = dat;
    endtask

    task automatic release_bus();
        bus.cyc    = 1'b0;
        bus.stb    = 1'b0;
        bus.adr    = '0;
        bus.we     = 1'b0;
        bus.sel    = '0;
        bus.dat_ms = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        release_bus();
        bus.gnt  = 1'b1;
        bus.lock = 1'b0;
        step();
        step();
        check("rst_valid", valid_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_data", data_o, 0);
        check("rst_we", we_o, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_rty", bus.rty, 0);
        check("rst_dat_sm", bus.dat_sm, 0);
        check("rst_tgd", bus.tgd_sm, 0);
        rst = 1'b0;
        step();

        // Write, zero-wait local logic
        snap();
        drive(32'h1000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
        step();
        check("wr_valid", valid_o, 1);
        check("wr_addr", addr_o, 32'h010);
        check("wr_we", we_o, 4'hF);
        check("wr_data", data_o, 32'hDEAD_BEEF);
        check("wr_noack_c1", bus.ack, 0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("wr_ack_c2", bus.ack, 1);
        check("wr_valid_drop", valid_o, 0);
        check("wr_dat_sm", bus.dat_sm, 0);
        release_bus();
        step();
        check("wr_ack_after", bus.ack, 0);
        check("wr_ack_once", n_ack - a0, 1);

        // Read with three wait cycles
        snap();
        drive(32'h1000_0004, 1'b0, 4'hF, 32'h0);
        step();
        check("rd_valid", valid_o, 1);
        check("rd_we", we_o, 0);
        check("rd_addr", addr_o, 32'h004);
        step();
        step();
        check("rd_wait_valid", valid_o, 1);
        check("rd_wait_noack", bus.ack, 0);
        check("rd_wait_dat", bus.dat_sm, 0);
        step();
        valid_i = 1'b1;
        data_i  = 32'hCAFE_0001;
        step();
        valid_i = 1'b0;
        data_i  = 32'h5555_AAAA;
        check("rd_ack", bus.ack, 1);
        check("rd_dat", bus.dat_sm, 32'hCAFE_0001);
        release_bus();
        step();
        check("rd_dat_after", bus.dat_sm, 0);
        check("rd_ack_once", n_ack - a0, 1);
        check("rd_one_req", n_req - q0, 1);

        // Burst of four reads, one access per three cycles
        snap();
        for (int i = 0; i < 4; i++) begin
            drive(32'h1000_0000 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            step();
            check($sformatf("burst%0d_addr", i), addr_o, 32'(4 * i));
            valid_i = 1'b1;
            data_i  = 32'hB000_0000 + 32'(i);
            step();
            valid_i = 1'b0;
            check($sformatf("burst%0d_ack", i), bus.ack, 1);
            check($sformatf("burst%0d_dat", i), bus.dat_sm, 32'hB000_0000 + 32'(i));
            step();
        end
        release_bus();
        step();
        check("burst_acks", n_ack - a0, 4);
        check("burst_reqs", n_req - q0, 4);

        // Misaligned access
        snap();
        drive(32'h1000_0002, 1'b0, 4'hF, 32'h0);
        step();
        check("mis_err_c1", bus.err, 1);
        check("mis_valid", valid_o, 0);
        check("mis_ack", bus.ack, 0);
        release_bus();
        step();
        check("mis_err_once", n_err - e0, 1);
        check("mis_no_req", n_req - q0, 0);

        // No byte lane selected
        snap();
        drive(32'h1000_0008, 1'b1, 4'h0, 32'h1);
        step();
        check("sel0_err", bus.err, 1);
        check("sel0_valid", valid_o, 0);
        release_bus();
        step();

        // Out-of-window access is ignored
        snap();
        drive(32'h2000_0000, 1'b1, 4'hF, 32'h1);
        repeat (4) step();
        release_bus();
        step();
        check("oow_resp", (n_ack - a0) + (n_err - e0) + (n_rty - r0), 0);
        check("oow_req", n_req - q0, 0);

        // Master abort while the request is pending
        snap();
        drive(32'h1000_0020, 1'b0, 4'hF, 32'h0);
        step();
        check("ab_valid", valid_o, 1);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        step();
        check("ab_valid_drop", valid_o, 0);
        step();
        check("ab_no_resp", (n_ack - a0) + (n_err - e0) + (n_rty - r0), 0);

        // Abort coinciding with local completion
        snap();
        drive(32'h1000_0024, 1'b1, 4'hF, 32'h1234);
        step();
        check("abv_valid", valid_o, 1);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("abv_valid_drop", valid_o, 0);
        step();
        check("abv_no_resp", (n_ack - a0) + (n_err - e0) + (n_rty - r0), 0);

        // Reset in the middle of a request
        snap();
        drive(32'h1000_0030, 1'b1, 4'h3, 32'hA5A5_5A5A);
        step();
        check("mrst_valid", valid_o, 1);
        check("mrst_we", we_o, 4'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        release_bus();
        check("mrst_valid_drop", valid_o, 0);
        check("mrst_addr", addr_o, 0);
        check("mrst_data", data_o, 0);
        check("mrst_we_clr", we_o, 0);
        step();
        step();
        check("mrst_no_resp", (n_ack - a0) + (n_err - e0) + (n_rty - r0), 0);

        // Slave is usable again after the mid-request reset
        snap();
        drive(32'h1000_0FFC, 1'b1, 4'h5, 32'h0F0F_0F0F);
        step();
        check("post_addr", addr_o, 32'hFFC);
        check("post_we", we_o, 4'h5);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("post_ack", bus.ack, 1);
        release_bus();
        step();

`ifdef WB_SLAVE_TIMEOUT_EN
        // No completion: four request cycles then retry
        snap();
        drive(32'h1000_0040, 1'b0, 4'hF, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("tmo_valid_c%0d", i), valid_o, 1);
            check($sformatf("tmo_norty_c%0d", i), bus.rty, 0);
        end
        step();
        check("tmo_rty", bus.rty, 1);
        check("tmo_valid_drop", valid_o, 0);
        check("tmo_noack", bus.ack, 0);
        release_bus();
        step();
        check("tmo_rty_once", n_rty - r0, 1);
        check("tmo_no_ack", n_ack - a0, 0);

        // Completion in the expiry cycle is acked
        snap();
        drive(32'h1000_0044, 1'b0, 4'hF, 32'h0);
        repeat (4) step();
        check("tmx_valid_c4", valid_o, 1);
        valid_i = 1'b1;
        data_i  = 32'h0BAD_F00D;
        step();
        valid_i = 1'b0;
        check("tmx_ack", bus.ack, 1);
        check("tmx_rty", bus.rty, 0);
        check("tmx_dat", bus.dat_sm, 32'h0BAD_F00D);
        release_bus();
        step();
        check("tmx_no_rty", n_rty - r0, 0);
`else
        // Without the timeout, a request waits indefinitely
        snap();
        drive(32'h1000_0040, 1'b0, 4'hF, 32'h0);
        repeat (20) step();
        check("wait_valid", valid_o, 1);
        check("wait_resp", (n_ack - a0) + (n_err - e0) + (n_rty - r0), 0);
        valid_i = 1'b1;
        data_i  = 32'h0BAD_F00D;
        step();
        valid_i = 1'b0;
        check("wait_ack", bus.ack, 1);
        check("wait_dat", bus.dat_sm, 32'h0BAD_F00D);
        release_bus();
        step();
        check("wait_no_rty", n_rty - r0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
